hw_rsp_collect: RTL and testbench
=================================

HW_RSP_COLLECT -- requirements
Module: hw_rsp_collect

Interface
REQ-001 Parameter P_NO_CH_VOLT, default 9: number of voltage channels; channel select is one-hot of this width.
REQ-002 Parameter P_NO_CH_TEMP, default 5: number of temperature result slots.
REQ-003 Parameter P_TIMEOUT, default 4096: maximum cycles from SOP accept to EOP accept.
REQ-004 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-005 rsp_valid_i  in  1, rsp_data_i  in  32, rsp_sop_i  in  1, rsp_eop_i  in  1: Avalon-ST response beats from the sensor controller.
REQ-006 rsp_ready_o  out  1: beat accepted when rsp_valid_i and rsp_ready_o are both high.
REQ-007 is_volt_i  in  1, is_temp_i  in  1: type of the outstanding command.
REQ-008 volt_ch_i  in  P_NO_CH_VOLT: one-hot voltage channel; temp_ch_i  in  4: temperature slot index.
REQ-009 done_o  out  1: one-cycle pulse per completed or aborted response; drives the command side's response input.
REQ-010 good_o  out  1: level, result of the last completed response.
REQ-011 rd_en_i  in  1, rd_addr_i  in  5, rd_data_o  out  32: result read port.

Function
REQ-012 States SHALL be IDLE, DATA, COMMIT.
REQ-013 IDLE: accepted beat with sop=1, eop=0 -> latch status = rsp_data_i[3:0], clear timer, clear good_o, go DATA.
REQ-014 IDLE: accepted beat with sop=1, eop=1 -> length error, go COMMIT.
REQ-015 IDLE: accepted beat with sop=0 -> stray beat; drop it, increment err_cnt, stay IDLE, no done_o.
REQ-016 DATA: accepted beat with eop=1, sop=0 -> latch rsp_data_i as sample, go COMMIT.
REQ-017 DATA: accepted beat with sop=1 (restart) or eop=0 (over-length) -> length error, go COMMIT; the beat is consumed.
REQ-018 DATA: timer reaching P_TIMEOUT-1 without an accepted beat -> timeout error, go COMMIT.
REQ-019 COMMIT lasts exactly one cycle, then IDLE; rsp_ready_o SHALL be 0 in COMMIT and 1 in IDLE and DATA.
REQ-020 Response good = status==0, no length or timeout error, exactly one of is_volt_i/is_temp_i high, and the channel valid.
REQ-021 Channel valid = volt_ch_i one-hot (volt) or temp_ch_i < P_NO_CH_TEMP (temp).
REQ-022 is_volt_i, is_temp_i, volt_ch_i and temp_ch_i SHALL be sampled in the COMMIT cycle.
REQ-023 COMMIT, good: write the sample to the selected result slot and set its valid bit.
REQ-024 COMMIT, not good: no slot write; increment err_cnt.
REQ-025 done_o SHALL pulse, and good_o SHALL be updated, on the cycle after COMMIT; latency from EOP accept to done_o is 2 cycles.
REQ-026 good_o SHALL hold until the next SOP is accepted in IDLE.
REQ-027 err_cnt SHALL be 16 bits and saturate at 0xFFFF.
REQ-028 Read map, 1-cycle latency, rd_data_o held between reads:
 - addresses 0..P_NO_CH_VOLT-1: voltage slots
 - next P_NO_CH_TEMP addresses: temperature slots
 - next address: {16'b0, err_cnt}
 - next address: {valid bits, zero-padded}
 - all other addresses: 0
REQ-029 A read and a write to the same slot in one cycle SHALL return the old value.

Reset
REQ-030 Reset SHALL force state IDLE and clear all of the following: done_o, good_o, err_cnt, timer, all result slots, all valid bits, and rd_data_o.
REQ-031 Reset SHALL force rsp_ready_o to 1.
REQ-032 Reset mid-packet SHALL abandon the packet with no done_o pulse.

Verification
- V1: is_volt_i=1, volt_ch_i=9'b000000100; beats {sop, 0x0} then {eop, 0x1234} -> done_o and good_o=1 two cycles after EOP accept; read addr 2 = 0x1234.
- V2: is_temp_i=1, temp_ch_i=3; status 0x5 then {eop, 0xABCD} -> done_o=1, good_o=0, err_cnt=1, read addr 12 = 0.
- V3: SOP then no beats for 4096 cycles -> done_o pulse, good_o=0, err_cnt increments; next SOP is accepted normally.
- V4: beat with sop=eop=1 in IDLE -> done_o, good_o=0. Separately, beat with sop=0 in IDLE -> no done_o, err_cnt+1.
- V5: is_temp_i=1, temp_ch_i=7 (>=5) with a valid packet -> good_o=0, no slot written.
- V6: assert reset between SOP and EOP -> no done_o; all reads return 0; a following full packet completes with good_o=1.

Source files
------------

// File: rtl/hw_rsp_collect.sv
// hw_rsp_collect: collects two-beat Avalon-ST sensor responses (status beat,
// sample beat), validates them against the outstanding command, stores good
// samples into per-channel result slots and reports completion to the
// command side. Results, error count and valid bits are readable through a
// simple registered read port.
module hw_rsp_collect #(
  parameter int P_NO_CH_VOLT = 9,
  parameter int P_NO_CH_TEMP = 5,
  parameter int P_TIMEOUT    = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rsp_valid_i,
  input  logic [31:0]             rsp_data_i,
  input  logic                    rsp_sop_i,
  input  logic                    rsp_eop_i,
  output logic                    rsp_ready_o,
  input  logic                    is_volt_i,
  input  logic                    is_temp_i,
  input  logic [P_NO_CH_VOLT-1:0] volt_ch_i,
  input  logic [3:0]              temp_ch_i,
  output logic                    done_o,
  output logic                    good_o,
  input  logic                    rd_en_i,
  input  logic [4:0]              rd_addr_i,
  output logic [31:0]             rd_data_o
);

  // Slot layout: voltage slots first, then temperature slots; the error
  // counter and the valid-bit vector follow directly after the slots.
  localparam int NSLOT = P_NO_CH_VOLT + P_NO_CH_TEMP;
  localparam int IW    = $clog2(NSLOT);
  localparam int TW    = $clog2(P_TIMEOUT);
  localparam int A_ERR = NSLOT;
  localparam int A_VLD = NSLOT + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e            state_q;
  logic              ready_q;
  logic              done_q;
  logic              good_q;
  logic [TW-1:0]     timer_q;
  logic [3:0]        status_q;
  logic [31:0]       sample_q;
  logic              len_err_q;
  logic              to_err_q;
  logic [15:0]       err_cnt_q;
  logic [15:0]       err_cnt_d;
  logic [31:0]       slots_q [NSLOT];
  logic [NSLOT-1:0]  valid_q;
  logic [31:0]       rd_data_q;

  logic              accept_s;
  logic              chan_ok_s;
  logic [IW-1:0]     slot_s;
  logic              good_s;
  logic              err_inc_s;

  // True when exactly one bit of the voltage channel select is set.
  function automatic logic is_onehot(input logic [P_NO_CH_VOLT-1:0] v);
    return (v != '0) && ((v & (v - P_NO_CH_VOLT'(1))) == '0);
  endfunction

  // Slot index of the (assumed one-hot) voltage channel select.
  function automatic logic [IW-1:0] onehot_idx(input logic [P_NO_CH_VOLT-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < P_NO_CH_VOLT; i++) begin
      if (v[i]) idx = IW'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  assign accept_s    = rsp_valid_i && ready_q;
  assign rsp_ready_o = ready_q;
  assign done_o      = done_q;
  assign good_o      = good_q;
  assign rd_data_o   = rd_data_q;

  // Command-side qualification, evaluated with the command inputs as they
  // stand in the COMMIT cycle.
  always_comb begin
    chan_ok_s = 1'b0;
    slot_s    = '0;
    good_s    = 1'b0;
    if (is_volt_i && !is_temp_i) begin
      chan_ok_s = is_onehot(volt_ch_i);
      slot_s    = onehot_idx(volt_ch_i);
    end else if (is_temp_i && !is_volt_i) begin
      chan_ok_s = (int'(temp_ch_i) < P_NO_CH_TEMP);
      slot_s    = IW'(P_NO_CH_VOLT) + IW'(temp_ch_i);
    end else begin
      chan_ok_s = 1'b0;
      slot_s    = '0;
    end
    good_s = chan_ok_s && (status_q == 4'd0) && !len_err_q && !to_err_q;
  end

  // Error events: stray beats in IDLE and every rejected response.
  always_comb begin
    err_inc_s = 1'b0;
    err_cnt_d = err_cnt_q;
    if (state_q == S_IDLE) begin
      err_inc_s = accept_s && !rsp_sop_i;
    end else if (state_q == S_COMMIT) begin
      err_inc_s = !good_s;
    end else begin
      err_inc_s = 1'b0;
    end
    if (err_inc_s && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Response FSM with its registered handshake/report outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      good_q    <= 1'b0;
      timer_q   <= '0;
      status_q  <= 4'd0;
      sample_q  <= 32'd0;
      len_err_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_s && rsp_sop_i && !rsp_eop_i) begin
            status_q  <= rsp_data_i[3:0];
            timer_q   <= '0;
            good_q    <= 1'b0;
            len_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            state_q   <= S_DATA;
          end else if (accept_s && rsp_sop_i && rsp_eop_i) begin
            // Single-beat packet carries no sample: reject as length error.
            len_err_q <= 1'b1;
            to_err_q  <= 1'b0;
            state_q   <= S_COMMIT;
            ready_q   <= 1'b0;
          end
        end
        S_DATA: begin
          if (accept_s) begin
            if (rsp_eop_i && !rsp_sop_i) begin
              sample_q <= rsp_data_i;
            end else begin
              // Restart or over-length beat: consumed, packet rejected.
              len_err_q <= 1'b1;
            end
            state_q <= S_COMMIT;
            ready_q <= 1'b0;
          end else if (timer_q == TW'(P_TIMEOUT - 1)) begin
            to_err_q <= 1'b1;
            state_q  <= S_COMMIT;
            ready_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_COMMIT: begin
          done_q  <= 1'b1;
          good_q  <= good_s;
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Saturating error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  // Result slots and valid bits, written only by a good COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        slots_q[i] <= 32'd0;
      end
      valid_q <= '0;
    end else if ((state_q == S_COMMIT) && good_s) begin
      slots_q[slot_s] <= sample_q;
      valid_q[slot_s] <= 1'b1;
    end
  end

  // Registered read port; reads the pre-write slot contents on a collision
  // and holds the last value when no read is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= 32'd0;
    end else if (rd_en_i) begin
      if (int'(rd_addr_i) < NSLOT) begin
        rd_data_q <= slots_q[rd_addr_i[IW-1:0]];
      end else if (int'(rd_addr_i) == A_ERR) begin
        rd_data_q <= {16'd0, err_cnt_q};
      end else if (int'(rd_addr_i) == A_VLD) begin
        rd_data_q <= 32'(valid_q);
      end else begin
        rd_data_q <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_hw_rsp_collect.sv
// Directed self-checking bench for hw_rsp_collect. Expected completion
// results and read data are pushed to scoreboard queues when stimulus is
// driven and popped when the DUT produces the corresponding output.
module tb_hw_rsp_collect;

  logic        clk = 1'b0;
  logic        reset;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        rsp_sop_i;
  logic        rsp_eop_i;
  logic        rsp_ready_o;
  logic        is_volt_i;
  logic        is_temp_i;
  logic [8:0]  volt_ch_i;
  logic [3:0]  temp_ch_i;
  logic        done_o;
  logic        good_o;
  logic        rd_en_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_o;

  int n_checks = 0;
  int n_err    = 0;
  int exp_err  = 0;

  logic        good_q[$];
  logic [31:0] rd_q[$];

  hw_rsp_collect dut (
    .clk         (clk),
    .reset       (reset),
    .rsp_valid_i (rsp_valid_i),
    .rsp_data_i  (rsp_data_i),
    .rsp_sop_i   (rsp_sop_i),
    .rsp_eop_i   (rsp_eop_i),
    .rsp_ready_o (rsp_ready_o),
    .is_volt_i   (is_volt_i),
    .is_temp_i   (is_temp_i),
    .volt_ch_i   (volt_ch_i),
    .temp_ch_i   (temp_ch_i),
    .done_o      (done_o),
    .good_o      (good_o),
    .rd_en_i     (rd_en_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted; returns 1ns after the
  // accepting edge.
  task automatic beat(input logic sop, input logic eop, input logic [31:0] d);
    int k;
    k = 0;
    rsp_valid_i = 1'b1;
    rsp_sop_i   = sop;
    rsp_eop_i   = eop;
    rsp_data_i  = d;
    while (rsp_ready_o !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) chk("beat_ready_timeout", 32'(k), 32'd0);
    tick();
    rsp_valid_i = 1'b0;
    rsp_sop_i   = 1'b0;
    rsp_eop_i   = 1'b0;
    rsp_data_i  = 32'd0;
  endtask

  // Wait (bounded) for done_o, check its latency, pop and compare good_o,
  // then check that done_o is a single-cycle pulse.
  task automatic wait_done(input string tag, input int lo, input int hi);
    int n;
    logic exp_g;
    n = 0;
    while (done_o !== 1'b1 && n < hi) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_lat_in_range"}, 32'((n >= lo) && (n <= hi)), 32'd1);
    exp_g = good_q.pop_front();
    chk({tag, "_good"}, 32'(good_o), 32'(exp_g));
    tick();
    chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] e;
    rd_q.push_back(exp);
    rd_en_i   = 1'b1;
    rd_addr_i = a;
    tick();
    rd_en_i   = 1'b0;
    rd_addr_i = 5'd0;
    e = rd_q.pop_front();
    chk(tag, rd_data_o, e);
  endtask

  // Full two-beat packet: status beat, then sample beat.
  task automatic pkt(input string tag, input logic [3:0] st, input logic [31:0] d, input logic g);
    beat(1'b1, 1'b0, {28'd0, st});
    good_q.push_back(g);
    beat(1'b0, 1'b1, d);
    if (!g) exp_err++;
    wait_done(tag, 1, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_cmd(input logic v, input logic t, input logic [8:0] vc, input logic [3:0] tc);
    is_volt_i = v;
    is_temp_i = t;
    volt_ch_i = vc;
    temp_ch_i = tc;
  endtask

  initial begin
    logic seen;
    reset       = 1'b1;
    rsp_valid_i = 1'b0;
    rsp_data_i  = 32'd0;
    rsp_sop_i   = 1'b0;
    rsp_eop_i   = 1'b0;
    rd_en_i     = 1'b0;
    rd_addr_i   = 5'd0;
    set_cmd(1'b0, 1'b0, 9'd0, 4'd0);
    do_reset();

    // Reset state
    chk("rst_ready", 32'(rsp_ready_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_good", 32'(good_o), 32'd0);
    chk("rst_rdata", rd_data_o, 32'd0);

    // V1: good voltage response on channel 2, EOP->done latency of 2 cycles
    set_cmd(1'b1, 1'b0, 9'b000000100, 4'd0);
    beat(1'b1, 1'b0, 32'h0);
    good_q.push_back(1'b1);
    beat(1'b0, 1'b1, 32'h1234);
    chk("v1_ready_commit", 32'(rsp_ready_o), 32'd0);
    chk("v1_done_early", 32'(done_o), 32'd0);
    wait_done("v1", 1, 1);
    chk("v1_ready_after", 32'(rsp_ready_o), 32'd1);
    rd("v1_slot2", 5'd2, 32'h1234);
    tick();
    chk("v1_rdata_held", rd_data_o, 32'h1234);
    chk("v1_good_level", 32'(good_o), 32'd1);
    rd("v1_valid", 5'd15, 32'h0000_0004);

    // V2: non-zero status on temperature slot 3; good_o clears at SOP
    set_cmd(1'b0, 1'b1, 9'd0, 4'd3);
    beat(1'b1, 1'b0, 32'h5);
    chk("v2_good_cleared_at_sop", 32'(good_o), 32'd0);
    good_q.push_back(1'b0);
    exp_err++;
    beat(1'b0, 1'b1, 32'hABCD);
    wait_done("v2", 1, 1);
    rd("v2_errcnt", 5'd14, 32'(exp_err));
    rd("v2_slot12", 5'd12, 32'd0);

    // V5: temperature slot index out of range; then a good temperature write
    set_cmd(1'b0, 1'b1, 9'd0, 4'd7);
    pkt("v5_oor", 4'd0, 32'h5555, 1'b0);
    set_cmd(1'b0, 1'b1, 9'd0, 4'd4);
    pkt("temp4", 4'd0, 32'hBEEF, 1'b1);
    rd("temp4_slot13", 5'd13, 32'hBEEF);
    rd("temp4_valid", 5'd15, 32'h0000_2004);

    // V4: single-beat packet, then a stray beat in IDLE
    set_cmd(1'b1, 1'b0, 9'b000000001, 4'd0);
    good_q.push_back(1'b0);
    exp_err++;
    beat(1'b1, 1'b1, 32'h0);
    wait_done("v4_sop_eop", 1, 1);
    beat(1'b0, 1'b1, 32'h77);
    exp_err++;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done_o === 1'b1) seen = 1'b1;
      tick();
    end
    chk("v4_stray_no_done", 32'(seen), 32'd0);
    rd("v4_errcnt", 5'd14, 32'(exp_err));

    // Over-length and restart beats inside a packet
    beat(1'b1, 1'b0, 32'h0);
    good_q.push_back(1'b0);
    exp_err++;
    beat(1'b0, 1'b0, 32'h11);
    wait_done("overlen", 1, 1);
    beat(1'b1, 1'b0, 32'h0);
    good_q.push_back(1'b0);
    exp_err++;
    beat(1'b1, 1'b0, 32'h0);
    wait_done("restart", 1, 1);

    // Bad command qualification: both types, and non-one-hot voltage select
    set_cmd(1'b1, 1'b1, 9'b000000100, 4'd0);
    pkt("both_types", 4'd0, 32'h2222, 1'b0);
    set_cmd(1'b1, 1'b0, 9'b000000011, 4'd0);
    pkt("not_onehot", 4'd0, 32'h3333, 1'b0);
    rd("bad_slot2_kept", 5'd2, 32'h1234);
    rd("bad_errcnt", 5'd14, 32'(exp_err));

    // Read and write of slot 2 in the same (COMMIT) cycle returns old data
    set_cmd(1'b1, 1'b0, 9'b000000100, 4'd0);
    beat(1'b1, 1'b0, 32'h0);
    beat(1'b0, 1'b1, 32'h9999);
    rd_q.push_back(32'h1234);
    rd_en_i   = 1'b1;
    rd_addr_i = 5'd2;
    tick();
    rd_en_i   = 1'b0;
    chk("rw_same_cycle_old", rd_data_o, rd_q.pop_front());
    chk("rw_done", 32'(done_o), 32'd1);
    chk("rw_good", 32'(good_o), 32'd1);
    rd("rw_slot2_new", 5'd2, 32'h9999);

    // V3: timeout after SOP, then a normal packet
    set_cmd(1'b1, 1'b0, 9'b000000001, 4'd0);
    beat(1'b1, 1'b0, 32'h0);
    good_q.push_back(1'b0);
    exp_err++;
    wait_done("v3_timeout", 4000, 4200);
    rd("v3_errcnt", 5'd14, 32'(exp_err));
    pkt("v3_after", 4'd0, 32'hCAFE, 1'b1);
    rd("v3_slot0", 5'd0, 32'hCAFE);
    rd("unmapped", 5'd20, 32'd0);

    // V6: reset mid-packet abandons it; everything reads back as zero
    beat(1'b1, 1'b0, 32'h0);
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) reset = 1'b0;
      if (done_o === 1'b1) seen = 1'b1;
      tick();
    end
    chk("v6_no_done", 32'(seen), 32'd0);
    chk("v6_good_cleared", 32'(good_o), 32'd0);
    for (int a = 0; a < 16; a++) begin
      rd("v6_read_zero", 5'(a), 32'd0);
    end
    exp_err = 0;
    set_cmd(1'b0, 1'b1, 9'd0, 4'd1);
    pkt("v6_after", 4'd0, 32'h600D, 1'b1);
    rd("v6_slot10", 5'd10, 32'h600D);
    rd("v6_errcnt", 5'd14, 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
